// File: rtl/mul_acc_core_if.sv
// Operand/result handshake bundle for mul_acc_core.
// slave  : the core's view (operands in, results out).
// master : the surrounding fetch/write logic's view.
interface mul_acc_core_if #(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned ACC_GUARD     = 4
) ();
  localparam int unsigned OUT_WIDTH = 2 * IN_DATA_WIDTH + ACC_GUARD;

  logic                     i_valid;
  logic                     o_ready;
  logic [IN_DATA_WIDTH-1:0] i_a;
  logic [IN_DATA_WIDTH-1:0] i_b;
  logic                     i_signed;
  logic                     i_acc;
  logic                     i_last;
  logic                     o_valid;
  logic                     i_ready;
  logic [OUT_WIDTH-1:0]     o_result;
  logic                     o_overflow;

  modport slave (
    input  i_valid, i_a, i_b, i_signed, i_acc, i_last, i_ready,
    output o_ready, o_valid, o_result, o_overflow
  );

  modport master (
    output i_valid, i_a, i_b, i_signed, i_acc, i_last, i_ready,
    input  o_ready, o_valid, o_result, o_overflow
  );
endinterface

// File: rtl/mul_acc_core.sv
// Pipelined multiply / multiply-accumulate core with valid/ready handshake.
// PIPE_STAGES product registers followed by one accumulate/output register.
// Optional build macro MUL_ACC_SATURATE_EN: the group accumulator clamps on
// overflow instead of wrapping (o_overflow is reported either way).
module mul_acc_core #(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned PIPE_STAGES   = 2,
  parameter int unsigned ACC_GUARD     = 4
) (
  input logic           clk,
  input logic           reset,
  mul_acc_core_if.slave bus
);
  localparam int unsigned W         = IN_DATA_WIDTH;
  localparam int unsigned OUT_WIDTH = 2 * W + ACC_GUARD;
  localparam int unsigned MSB       = OUT_WIDTH - 1;

  typedef struct packed {
    logic                 valid;
    logic                 sgn;
    logic                 acc;
    logic                 last;
    logic [OUT_WIDTH-1:0] prod;
  } stage_t;

  stage_t               pipe [PIPE_STAGES];
  stage_t               tail;
  logic                 stall;
  logic [2*W-1:0]       prod_u;
  logic [2*W-1:0]       prod_s;
  logic [OUT_WIDTH-1:0] prod_ext;
  logic [OUT_WIDTH-1:0] acc_q;
  logic                 ovf_q;
  logic [OUT_WIDTH:0]   sum_wide;
  logic [OUT_WIDTH-1:0] sum;
  logic [OUT_WIDTH-1:0] acc_next;
  logic                 add_ovf;
  logic                 ovf_next;

  assign stall       = bus.o_valid && !bus.i_ready;
  assign bus.o_ready = !stall;
  assign tail        = pipe[PIPE_STAGES-1];

  // Product of the incoming operands, extended by the beat's signedness.
  // The signed product is the low 2W bits of the sign-extended operands' product.
  always_comb begin
    prod_u = {{W{1'b0}}, bus.i_a} * {{W{1'b0}}, bus.i_b};
    prod_s = {{W{bus.i_a[W-1]}}, bus.i_a} * {{W{bus.i_b[W-1]}}, bus.i_b};
    if (bus.i_signed) prod_ext = {{ACC_GUARD{prod_s[2*W-1]}}, prod_s};
    else              prod_ext = {{ACC_GUARD{1'b0}}, prod_u};
  end

  // Product pipeline; the whole pipe freezes while the output is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < PIPE_STAGES; i++) pipe[i] <= '0;
    end else if (!stall) begin
      pipe[0] <= '{valid: bus.i_valid, sgn: bus.i_signed, acc: bus.i_acc,
                   last: bus.i_last, prod: prod_ext};
      for (int unsigned i = 1; i < PIPE_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Accumulator add with overflow detection using the tail beat's signedness.
  always_comb begin
    sum_wide = {1'b0, acc_q} + {1'b0, tail.prod};
    sum      = sum_wide[OUT_WIDTH-1:0];
    if (tail.sgn) add_ovf = (acc_q[MSB] == tail.prod[MSB]) && (sum[MSB] != acc_q[MSB]);
    else          add_ovf = sum_wide[OUT_WIDTH];
    ovf_next = ovf_q | add_ovf;
`ifdef MUL_ACC_SATURATE_EN
    // Once clamped the group value is frozen; the clamp direction follows the
    // accumulator sign, since signed overflow needs both addends of that sign.
    if (ovf_q)        acc_next = acc_q;
    else if (add_ovf) acc_next = tail.sgn ? {acc_q[MSB], {(OUT_WIDTH-1){~acc_q[MSB]}}} : '1;
    else              acc_next = sum;
`else
    acc_next = sum;
`endif
  end

  // Accumulate/output register: emits single products and closed group sums.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q          <= '0;
      ovf_q          <= 1'b0;
      bus.o_valid    <= 1'b0;
      bus.o_result   <= '0;
      bus.o_overflow <= 1'b0;
    end else if (!stall) begin
      if (tail.valid && tail.acc) begin
        if (tail.last) begin
          bus.o_result   <= acc_next;
          bus.o_overflow <= ovf_next;
          bus.o_valid    <= 1'b1;
          acc_q          <= '0;
          ovf_q          <= 1'b0;
        end else begin
          acc_q       <= acc_next;
          ovf_q       <= ovf_next;
          bus.o_valid <= 1'b0;
        end
      end else if (tail.valid) begin
        bus.o_result   <= tail.prod;
        bus.o_overflow <= 1'b0;
        bus.o_valid    <= 1'b1;
      end else begin
        bus.o_valid <= 1'b0;
      end
    end
  end
endmodule
